// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle radix-2 restoring integer divider (UDIV / SDIV). It produces one
//   quotient bit per clock. A start pulse latches the operands. busy stays high
//   for exactly WIDTH cycles while the quotient is built. done then pulses for
//   one cycle, and the registered results hold until the next op completes.
//   Signed operation divides magnitudes and then fixes the signs: the quotient
//   truncates toward zero and the remainder takes the sign of the dividend.
//   Dividing by zero skips the iteration and returns q=0, r=a, div_zero=1.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      op request, ignored while busy
//   is_signed  in   1      1 = SDIV, 0 = UDIV; sampled with start
//   a          in   WIDTH  dividend; sampled with start
//   b          in   WIDTH  divisor; sampled with start
//   busy       out  1      high while iterating
//   done       out  1      one-cycle pulse, results valid
//   quotient   out  WIDTH  quotient of last completed op
//   remainder  out  WIDTH  remainder of last completed op
//   div_zero   out  1      last completed op had b == 0
//   ALUFlags   out  4      {N,Z,C,V} of quotient; C and V always 0
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [3:0]       ALUFlags
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_dvd;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_div;      // divisor magnitude
  logic [CW-1:0]    r_count;    // iterations left after the current one
  logic             r_q_neg;
  logic             r_r_neg;

  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_diff;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;
  logic             w_last;

  assign w_b_zero = (b == '0);

  // Negating MIN_INT yields MIN_INT, which is exactly its unsigned magnitude.
  assign w_a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // The shifted remainder can reach 2*|b|-1, so it needs one extra bit for
  // the compare. When the compare passes, the difference is below |b| and
  // fits in WIDTH bits, so the low-order subtract is exact.
  assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_div;
  assign w_rem_next = w_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
  assign w_q_mag    = {r_dvd[WIDTH-2:0], w_ge};
  assign w_last     = (r_count == '0);

  // Negating a zero result gives zero again, so zero is never made negative.
  assign w_q_final = r_q_neg ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_r_final = r_r_neg ? (~w_rem_next + 1'b1) : w_rem_next;

  // NOTE: every output of a combinational block gets a default before the case,
  // so that no path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_next = w_b_zero ? S_DONE : S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset along with the control state.
      // The visible results must read zero after reset, and the divider has
      // only a handful of registers.
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_div     <= '0;
      r_count   <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ALUFlags  <= 4'b0100;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (w_b_zero) begin
              quotient  <= '0;
              remainder <= a;
              div_zero  <= 1'b1;
              ALUFlags  <= 4'b0100;
            end else begin
              r_rem   <= '0;
              r_dvd   <= w_a_mag;
              r_div   <= w_b_mag;
              r_q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              r_r_neg <= is_signed & a[WIDTH-1];
              r_count <= CW'(WIDTH - 1);
            end
          end
        end
        S_CALC: begin
          r_rem   <= w_rem_next;
          r_dvd   <= w_q_mag;
          r_count <= r_count - 1'b1;
          if (w_last) begin
            quotient  <= w_q_final;
            remainder <= w_r_final;
            div_zero  <= 1'b0;
            ALUFlags  <= {w_q_final[WIDTH-1], (w_q_final == '0), 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
